// File: rtl/sram_like_ram.sv
// rtl/sram_like_ram.sv - word RAM responder for the sram-like handshake, fixed latency, in-order responses
// Optional pseudo-random accept stalls: define SRAM_LIKE_RAM_RANDSTALL_EN.
module sram_like_ram #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int CD_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CD_W-1:0]  CD_INIT  = CD_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(QDEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [31:0]       q_data [QDEPTH];
    logic [CD_W-1:0]   q_cd   [QDEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] idx;
    logic [3:0]        strb;
    logic              space;
    logic              accept;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign idx = addr[ADDR_W+1:2];

    always_comb begin
        strb = 4'b1111;
        case (size)
            2'd0:    strb = 4'b0001 << addr[1:0];
            2'd1:    strb = addr[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
    end

    // Registered count only: a pop in this cycle does not free a slot until next cycle.
    assign space = (count < CNT_MAX);

`ifdef SRAM_LIKE_RAM_RANDSTALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign addr_ok = space & ~lfsr[0];
`else
    assign addr_ok = space;
`endif

    assign accept  = req & addr_ok;
    assign data_ok = (count != '0) && (q_cd[rd_ptr] == '0);
    assign rdata   = data_ok ? q_data[rd_ptr] : 32'd0;

    // RAM contents survive reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (accept && wr && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_data[i] <= 32'd0;
                q_cd[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (q_cd[i] != '0) begin
                    q_cd[i] <= q_cd[i] - CD_W'(1);
                end
            end
            // The push slot is always free, so this overrides any decrement above.
            if (accept) begin
                q_data[wr_ptr] <= wr ? 32'd0 : mem[idx];
                q_cd[wr_ptr]   <= CD_INIT;
                wr_ptr         <= ptr_next(wr_ptr);
            end
            if (data_ok) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({accept, data_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
